// File: rtl/mem_cmd_entry.sv
// Pushbutton/switch front end for the memory controller: synchronises and debounces
// two active-low keys, builds a 16-bit entry word, and issues single read/write requests.
module mem_cmd_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        key_n,
  input  logic [9:0]        sw,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [15:0]       req_data,
  output logic [15:0]       entry_val,
  output logic              busy
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic [1:0]        sync1, sync2, db;
  logic [CW-1:0]     cnt [2];
  logic [1:0]        press;
  logic [ADDR_W-1:0] addr_q;

  // Press fires in the same cycle the debounced level is updated to 0.
  always_comb begin
    press = '0;
    for (int unsigned k = 0; k < 2; k++)
      press[k] = db[k] & ~sync2[k] & (cnt[k] == CMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      db     <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int unsigned k = 0; k < 2; k++) begin
        if (sync2[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CMAX) begin
          db[k]  <= sync2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_data  <= '0;
      entry_val <= '0;
      busy      <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press[1]) begin
            case (sw[9:8])
              2'b00: addr_q <= sw[ADDR_W-1:0];
              2'b01, 2'b10: begin
                req_write <= sw[9];
                req_addr  <= addr_q;
                req_data  <= entry_val;
                req_valid <= 1'b1;
                busy      <= 1'b1;
                state     <= REQ;
              end
              default: begin
                entry_val <= '0;
                addr_q    <= '0;
              end
            endcase
          end else if (press[0]) begin
            entry_val <= {entry_val[11:0], sw[3:0]};
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_entry.sv
// Self-checking bench for mem_cmd_entry: directed table, multi-cycle corner sequences,
// and randomized key operations against an operation-level reference model.
module tb_mem_cmd_entry;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  key_n = 2'b11;
  logic [9:0]  sw = '0;
  logic        req_ready = 1'b0;
  logic        req_valid, req_write, busy;
  logic [7:0]  req_addr;
  logic [15:0] req_data, entry_val;

  int tests = 0;
  int failed = 0;
  int acc = 0;

  mem_cmd_entry #(.DEBOUNCE_CYCLES(D), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .entry_val(entry_val), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && req_valid && req_ready) acc++;

  typedef struct {
    logic        go;
    logic [9:0]  sw;
    int          stall;
    logic [15:0] exp_entry;
    logic        exp_valid;
    logic        exp_write;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int k);
    key_n[k] = 1'b0;
    repeat (D + 6) tick();
    key_n[k] = 1'b1;
    repeat (D + 6) tick();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    sw = v.sw;
    press(v.go ? 1 : 0);
    chk({tag, " entry"}, 32'(entry_val), 32'(v.exp_entry));
    chk({tag, " valid"}, 32'(req_valid), 32'(v.exp_valid));
    chk({tag, " busy"}, 32'(busy), 32'(v.exp_valid));
    if (v.exp_valid) begin
      chk({tag, " write"}, 32'(req_write), 32'(v.exp_write));
      chk({tag, " addr"}, 32'(req_addr), 32'(v.exp_addr));
      chk({tag, " data"}, 32'(req_data), 32'(v.exp_data));
      for (int i = 0; i < v.stall; i++) begin
        sw = 10'($urandom);
        tick();
        chk({tag, " hold"}, {req_valid, busy, req_write, req_addr, req_data[12:0]},
            {1'b1, 1'b1, v.exp_write, v.exp_addr, v.exp_data[12:0]});
      end
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk({tag, " done"}, {req_valid, busy}, 32'b0);
    end
  endtask

  vec_t tbl [6];
  vec_t v;
  logic [15:0] m_entry;
  logic [7:0]  m_addr;
  int          acc0;

  initial begin
    tbl[0] = '{1'b0, 10'h00A, 0, 16'h00AA, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[1] = '{1'b0, 10'h00B, 0, 16'h0AAB, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[2] = '{1'b0, 10'h00C, 0, 16'hAABC, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[3] = '{1'b0, 10'h00D, 0, 16'hABCD, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[4] = '{1'b1, 10'h03C, 0, 16'hABCD, 1'b0, 1'b0, 8'h00, 16'h0000};
    tbl[5] = '{1'b1, 10'h255, 5, 16'hABCD, 1'b1, 1'b1, 8'h3C, 16'hABCD};

    repeat (3) tick();
    reset = 1'b0;
    chk("reset outputs", {req_valid, req_write, req_addr, req_data, entry_val, busy}, 32'b0);
    repeat (D + 6) tick();
    chk("idle no event", 32'(entry_val), 32'h0);

    // short glitch is filtered
    sw = 10'h00A;
    key_n[0] = 1'b0; repeat (D - 1) tick(); key_n[0] = 1'b1;
    repeat (D + 6) tick();
    chk("glitch", 32'(entry_val), 32'h0);

    // bounce then steady low: exactly one shift
    key_n[0] = 1'b0; repeat (2) tick();
    key_n[0] = 1'b1; tick();
    key_n[0] = 1'b0; repeat (D + 6) tick();
    key_n[0] = 1'b1; repeat (D + 6) tick();
    chk("bounce shift", 32'(entry_val), 32'h000A);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // READ, then presses while busy are discarded
    acc0 = acc;
    sw = 10'h100;
    press(1);
    chk("read valid", {req_valid, req_write, req_addr, req_data}, {1'b1, 1'b0, 8'h3C, 16'hABCD});
    sw = 10'h205;
    press(0);
    press(1);
    chk("busy hold", {req_valid, busy, req_write, entry_val}, {1'b1, 1'b1, 1'b0, 16'hABCD});
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    repeat (D + 6) tick();
    chk("busy discard", {req_valid, busy, entry_val}, {1'b0, 1'b0, 16'hABCD});
    chk("one read", 32'(acc - acc0), 32'd1);

    // reset mid-request abandons it and clears the address register
    sw = 10'h200;
    press(1);
    chk("write pending", 32'(req_valid), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset mid req", {req_valid, busy, entry_val, req_addr}, 32'b0);
    v = '{1'b1, 10'h100, 1, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000};
    run_vec(v, "post-reset read");

    // CLEAR with ABCD loaded
    for (int i = 0; i < 4; i++) begin
      sw = 10'(10 + i);
      press(0);
    end
    chk("reload", 32'(entry_val), 32'hABCD);
    v = '{1'b1, 10'h300, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000};
    run_vec(v, "clear");

    // simultaneous presses: GO (LOAD_ADDR) wins, SHIFT dropped
    sw = 10'h057;
    key_n = 2'b00; repeat (D + 6) tick();
    key_n = 2'b11; repeat (D + 6) tick();
    chk("both no shift", 32'(entry_val), 32'h0);
    v = '{1'b1, 10'h100, 2, 16'h0000, 1'b1, 1'b0, 8'h57, 16'h0000};
    run_vec(v, "both addr");

    // randomized operations against the operation-level model
    v = '{1'b1, 10'h300, 0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000};
    run_vec(v, "rclear");
    m_entry = 16'h0;
    m_addr  = 8'h0;
    for (int i = 0; i < 40; i++) begin
      v.go = 1'($urandom_range(0, 1));
      v.sw = 10'($urandom);
      v.stall = int'($urandom_range(0, 3));
      v.exp_valid = 1'b0;
      v.exp_write = 1'b0;
      v.exp_addr = m_addr;
      v.exp_data = m_entry;
      if (!v.go) begin
        m_entry = 16'((32'(m_entry) * 16 + 32'(v.sw % 16)) % 65536);
      end else begin
        case (v.sw / 256)
          0: m_addr = 8'(v.sw % 256);
          1, 2: begin
            v.exp_valid = 1'b1;
            v.exp_write = (v.sw / 256 == 2);
          end
          default: begin
            m_entry = 16'h0;
            m_addr  = 8'h0;
          end
        endcase
      end
      v.exp_entry = m_entry;
      run_vec(v, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
